pipe_ctrl_unit: RTL and testbench

//  Parametrised successor to the combinational main decoder. Decodes RV32I control bundles in ID
//  and carries them through ID/EX, EX/MEM and MEM/WB control registers with global stall, branch

---
 rtl/pipe_ctrl_unit.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// RV32I control decoder plus ID/EX, EX/MEM and MEM/WB control registers with
// global stall, branch flush and load-use bubble insertion.
module pipe_ctrl_unit #(
    parameter int ALU_OP_W  = 4,
    parameter int REG_W     = 5,
    parameter int LU_DETECT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [6:0]          op_code,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [REG_W-1:0]    rd,
    input  logic                stall_in,
    input  logic                flush,
    output logic                hazard_stall,
    output logic [ALU_OP_W:0]   ex_ctrl,
    output logic [3:0]          ex_m,
    output logic [3:0]          mem_m,
    output logic [2:0]          wb_ctrl,
    output logic [REG_W-1:0]    wb_rd,
    output logic                illegal_ex,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic LU_EN = (LU_DETECT != 0);

    // Decoded bundle for the instruction currently in ID
    logic [ALU_OP_W-1:0] dec_alu_op_s;
    logic                dec_src_b_s;
    logic [3:0]          dec_m_s;      // {branch, b_type, mem_write, mem_read}
    logic [2:0]          dec_wb_s;     // {reg_write, mem_to_reg[1:0]}
    logic                dec_illegal_s;

    // Pipeline registers
    logic [ALU_OP_W-1:0] idex_alu_op_r;
    logic                idex_src_b_r;
    logic [3:0]          idex_m_r;
    logic [2:0]          idex_wb_r;
    logic [REG_W-1:0]    idex_rd_r;
    logic                idex_illegal_r;
    logic [3:0]          exmem_m_r;
    logic [2:0]          exmem_wb_r;
    logic [REG_W-1:0]    exmem_rd_r;
    logic [2:0]          memwb_wb_r;
    logic [REG_W-1:0]    memwb_rd_r;
    logic [CNT_W-1:0]    bubble_cnt_r;

    logic                uses_rs2_s;
    logic                load_use_s;

    // Main decoder: a zero bundle doubles as a pipeline bubble
    always_comb begin
        dec_alu_op_s  = '0;
        dec_src_b_s   = 1'b0;
        dec_m_s       = 4'b0000;
        dec_wb_s      = 3'b000;
        dec_illegal_s = 1'b0;
        if (id_valid) begin
            case (op_code)
                OPC_OP_IMM: begin
                    dec_wb_s     = 3'b100;
                    dec_src_b_s  = 1'b1;
                    // only shift-right immediates carry an alternate-op bit
                    dec_alu_op_s = ALU_OP_W'({(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3});
                end
                OPC_OP: begin
                    dec_wb_s     = 3'b100;
                    dec_alu_op_s = ALU_OP_W'({funct7_5, funct3});
                end
                OPC_LOAD: begin
                    dec_wb_s    = 3'b111;
                    dec_src_b_s = 1'b1;
                    dec_m_s     = 4'b0001;
                end
                OPC_STORE: begin
                    dec_src_b_s = 1'b1;
                    dec_m_s     = 4'b0010;
                end
                OPC_BRANCH: begin
                    dec_alu_op_s = ALU_OP_W'(4'b1000);
                    dec_m_s      = {1'b1, (funct3 == 3'b000), 2'b00};
                end
                OPC_LUI: begin
                    dec_wb_s = 3'b101;
                end
                OPC_JAL: begin
                    dec_wb_s = 3'b110;
                end
                OPC_JALR: begin
                    dec_wb_s    = 3'b110;
                    dec_src_b_s = 1'b1;
                end
                default: begin
                    dec_illegal_s = 1'b1;
                end
            endcase
        end else begin
            dec_illegal_s = 1'b0;
        end
    end

    // Load-use detection against the load sitting in ID/EX
    always_comb begin
        uses_rs2_s = 1'b0;
        load_use_s = 1'b0;
        case (op_code)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2_s = 1'b1;
            default:                       uses_rs2_s = 1'b0;
        endcase
        if (LU_EN && idex_m_r[0] && (idex_rd_r != '0) && id_valid) begin
            load_use_s = (idex_rd_r == rs1) || ((idex_rd_r == rs2) && uses_rs2_s);
        end else begin
            load_use_s = 1'b0;
        end
    end

    assign hazard_stall = load_use_s & ~flush;

    // Control pipeline: stall holds everything, flush/load-use inject a bubble into ID/EX
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_alu_op_r  <= '0;
            idex_src_b_r   <= 1'b0;
            idex_m_r       <= 4'b0000;
            idex_wb_r      <= 3'b000;
            idex_rd_r      <= '0;
            idex_illegal_r <= 1'b0;
            exmem_m_r      <= 4'b0000;
            exmem_wb_r     <= 3'b000;
            exmem_rd_r     <= '0;
            memwb_wb_r     <= 3'b000;
            memwb_rd_r     <= '0;
        end else if (stall_in) begin
            idex_alu_op_r  <= idex_alu_op_r;
            idex_src_b_r   <= idex_src_b_r;
            idex_m_r       <= idex_m_r;
            idex_wb_r      <= idex_wb_r;
            idex_rd_r      <= idex_rd_r;
            idex_illegal_r <= idex_illegal_r;
            exmem_m_r      <= exmem_m_r;
            exmem_wb_r     <= exmem_wb_r;
            exmem_rd_r     <= exmem_rd_r;
            memwb_wb_r     <= memwb_wb_r;
            memwb_rd_r     <= memwb_rd_r;
        end else begin
            exmem_m_r  <= idex_m_r;
            exmem_wb_r <= idex_wb_r;
            exmem_rd_r <= idex_rd_r;
            memwb_wb_r <= exmem_wb_r;
            memwb_rd_r <= exmem_rd_r;
            if (flush || load_use_s) begin
                idex_alu_op_r  <= '0;
                idex_src_b_r   <= 1'b0;
                idex_m_r       <= 4'b0000;
                idex_wb_r      <= 3'b000;
                idex_rd_r      <= '0;
                idex_illegal_r <= 1'b0;
            end else begin
                idex_alu_op_r  <= dec_alu_op_s;
                idex_src_b_r   <= dec_src_b_s;
                idex_m_r       <= dec_m_s;
                idex_wb_r      <= dec_wb_s;
                idex_rd_r      <= rd;
                idex_illegal_r <= dec_illegal_s;
            end
        end
    end

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= '0;
        end else if (!stall_in && !flush && load_use_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_W'(1'b1);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_ctrl    = {idex_src_b_r, idex_alu_op_r};
    assign ex_m       = idex_m_r;
    assign illegal_ex = idex_illegal_r;
    assign mem_m      = exmem_m_r;
    assign wb_ctrl    = memwb_wb_r;
    assign wb_rd      = memwb_rd_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, latency, load-use, flush/stall priority,
// illegal opcodes and counter saturation (second instance with a 2-bit counter).
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] op_code = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       stall_in = 1'b0;
    logic       flush = 1'b0;

    logic        hazard_stall, illegal_ex;
    logic [4:0]  ex_ctrl, wb_rd;
    logic [3:0]  ex_m, mem_m;
    logic [2:0]  wb_ctrl;
    logic [15:0] bubble_cnt;

    logic        s_hazard_stall, s_illegal_ex;
    logic [4:0]  s_ex_ctrl, s_wb_rd;
    logic [3:0]  s_ex_m, s_mem_m;
    logic [2:0]  s_wb_ctrl;
    logic [1:0]  s_bubble_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op_code(op_code), .funct3(funct3),
        .funct7_5(funct7_5), .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
        .hazard_stall(hazard_stall), .ex_ctrl(ex_ctrl), .ex_m(ex_m), .mem_m(mem_m),
        .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .illegal_ex(illegal_ex), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op_code(op_code), .funct3(funct3),
        .funct7_5(funct7_5), .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
        .hazard_stall(s_hazard_stall), .ex_ctrl(s_ex_ctrl), .ex_m(s_ex_m), .mem_m(s_mem_m),
        .wb_ctrl(s_wb_ctrl), .wb_rd(s_wb_rd), .illegal_ex(s_illegal_ex), .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        id_valid = v; op_code = opc; funct3 = f3; funct7_5 = f7; rs1 = a; rs2 = b; rd = d;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        idle();
        stall_in = 1'b0; flush = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        rst = 1'b1;
        tick(); tick();
        total++; if ({ex_ctrl, ex_m, mem_m, wb_ctrl, wb_rd, illegal_ex, hazard_stall} !== 23'd0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {ex_ctrl, ex_m, mem_m, wb_ctrl, wb_rd, illegal_ex, hazard_stall}); end
        total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        tick();
        total++; if ({ex_ctrl, ex_m} !== 9'b0_0000_0000) begin bad++; $display("FAIL add_ex got=%b exp=%b", {ex_ctrl, ex_m}, 9'b0); end
        idle(); tick(); tick();
        total++; if ({wb_ctrl, wb_rd} !== {3'b100, 5'd3}) begin bad++; $display("FAIL add_wb got=%b exp=%b", {wb_ctrl, wb_rd}, {3'b100, 5'd3}); end
    endtask

    task automatic test_alu();
        do_reset();
        drive(1'b1, OP, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4); tick();
        total++; if (ex_ctrl !== 5'b0_1000) begin bad++; $display("FAIL sub_ctrl got=%b exp=01000", ex_ctrl); end
        drive(1'b1, OP_IMM, 3'b101, 1'b1, 5'd1, 5'd0, 5'd4); tick();
        total++; if (ex_ctrl !== 5'b1_1101) begin bad++; $display("FAIL srai_ctrl got=%b exp=11101", ex_ctrl); end
        drive(1'b1, OP_IMM, 3'b110, 1'b1, 5'd1, 5'd0, 5'd4); tick();
        total++; if (ex_ctrl !== 5'b1_0110) begin bad++; $display("FAIL ori_ctrl got=%b exp=10110", ex_ctrl); end
        drive(1'b1, BRANCH, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0); tick();
        total++; if ({ex_ctrl, ex_m} !== {5'b0_1000, 4'b1000}) begin bad++; $display("FAIL bne_ex got=%b exp=%b", {ex_ctrl, ex_m}, {5'b0_1000, 4'b1000}); end
        drive(1'b1, JALR, 3'b000, 1'b0, 5'd1, 5'd0, 5'd9); tick();
        total++; if (ex_ctrl !== 5'b1_0000) begin bad++; $display("FAIL jalr_ctrl got=%b exp=10000", ex_ctrl); end
        idle(); tick(); tick();
        total++; if ({wb_ctrl, wb_rd} !== {3'b110, 5'd9}) begin bad++; $display("FAIL jalr_wb got=%b exp=%b", {wb_ctrl, wb_rd}, {3'b110, 5'd9}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        total++; if ({ex_ctrl, ex_m} !== {5'b1_0000, 4'b0001}) begin bad++; $display("FAIL lw_ex got=%b exp=%b", {ex_ctrl, ex_m}, {5'b1_0000, 4'b0001}); end
        drive(1'b1, STORE, 3'b010, 1'b0, 5'd2, 5'd3, 5'd0); #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL sw_nohaz got=%b exp=0", hazard_stall); end
        tick();
        total++; if ({ex_m, mem_m} !== {4'b0010, 4'b0001}) begin bad++; $display("FAIL sw_stage got=%b exp=%b", {ex_m, mem_m}, {4'b0010, 4'b0001}); end
        drive(1'b1, BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0); tick();
        total++; if ({ex_m, mem_m, wb_ctrl, wb_rd} !== {4'b1100, 4'b0010, 3'b111, 5'd5}) begin
            bad++; $display("FAIL beq_stage got=%b exp=%b", {ex_m, mem_m, wb_ctrl, wb_rd}, {4'b1100, 4'b0010, 3'b111, 5'd5}); end
        drive(1'b1, JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1); tick();
        total++; if ({ex_ctrl, ex_m, mem_m, wb_ctrl} !== {5'b0, 4'b0000, 4'b1100, 3'b000}) begin
            bad++; $display("FAIL jal_stage got=%b exp=%b", {ex_ctrl, ex_m, mem_m, wb_ctrl}, {5'b0, 4'b0000, 4'b1100, 3'b000}); end
        drive(1'b1, LUI, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7); tick();
        total++; if ({mem_m, wb_ctrl} !== {4'b0000, 3'b000}) begin bad++; $display("FAIL post_jal got=%b exp=%b", {mem_m, wb_ctrl}, {4'b0000, 3'b000}); end
        idle(); tick();
        total++; if ({wb_ctrl, wb_rd} !== {3'b110, 5'd1}) begin bad++; $display("FAIL jal_wb got=%b exp=%b", {wb_ctrl, wb_rd}, {3'b110, 5'd1}); end
        tick();
        total++; if ({wb_ctrl, wb_rd} !== {3'b101, 5'd7}) begin bad++; $display("FAIL lui_wb got=%b exp=%b", {wb_ctrl, wb_rd}, {3'b101, 5'd7}); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, OP, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6); #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%b exp=1", hazard_stall); end
        tick();
        total++; if ({ex_m, mem_m, hazard_stall} !== {4'b0000, 4'b0001, 1'b0}) begin
            bad++; $display("FAIL lu_bubble got=%b exp=%b", {ex_m, mem_m, hazard_stall}, {4'b0000, 4'b0001, 1'b0}); end
        total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", bubble_cnt); end
        tick();
        total++; if ({mem_m, wb_ctrl, wb_rd} !== {4'b0000, 3'b111, 5'd5}) begin
            bad++; $display("FAIL lu_resume got=%b exp=%b", {mem_m, wb_ctrl, wb_rd}, {4'b0000, 3'b111, 5'd5}); end
        idle(); tick(); tick();
        total++; if ({wb_ctrl, wb_rd, bubble_cnt} !== {3'b100, 5'd6, 16'd1}) begin
            bad++; $display("FAIL lu_add_wb got=%b exp=%b", {wb_ctrl, wb_rd, bubble_cnt}, {3'b100, 5'd6, 16'd1}); end
    endtask

    task automatic test_no_stall();
        do_reset();
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, LUI, 3'b000, 1'b0, 5'd0, 5'd5, 5'd5); #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lui_nohaz got=%b exp=0", hazard_stall); end
        tick();
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, OP_IMM, 3'b000, 1'b0, 5'd1, 5'd5, 5'd7); #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL addi_nohaz got=%b exp=0", hazard_stall); end
        tick();
        total++; if ({ex_ctrl, ex_m} !== {5'b1_0000, 4'b0000}) begin bad++; $display("FAIL addi_ex got=%b exp=%b", {ex_ctrl, ex_m}, {5'b1_0000, 4'b0000}); end
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, STORE, 3'b010, 1'b0, 5'd1, 5'd5, 5'd0); #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL sw_rs2_haz got=%b exp=1", hazard_stall); end
        tick();
        total++; if ({ex_m, bubble_cnt} !== {4'b0000, 16'd1}) begin bad++; $display("FAIL sw_rs2_bubble got=%b exp=%b", {ex_m, bubble_cnt}, {4'b0000, 16'd1}); end
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0); tick();
        drive(1'b1, OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8); #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL x0_nohaz got=%b exp=0", hazard_stall); end
        idle();
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, STORE, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0); tick();
        drive(1'b1, BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
        flush = 1'b1; stall_in = 1'b1;
        tick();
        total++; if ({ex_m, mem_m, wb_ctrl} !== {4'b0010, 4'b0001, 3'b000}) begin
            bad++; $display("FAIL stall_hold got=%b exp=%b", {ex_m, mem_m, wb_ctrl}, {4'b0010, 4'b0001, 3'b000}); end
        stall_in = 1'b0;
        tick();
        total++; if ({ex_m, mem_m, wb_ctrl, wb_rd} !== {4'b0000, 4'b0010, 3'b111, 5'd5}) begin
            bad++; $display("FAIL flush_squash got=%b exp=%b", {ex_m, mem_m, wb_ctrl, wb_rd}, {4'b0000, 4'b0010, 3'b111, 5'd5}); end
        flush = 1'b0;
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, OP, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6);
        flush = 1'b1; #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL flush_masks_haz got=%b exp=0", hazard_stall); end
        tick();
        total++; if ({ex_m, bubble_cnt} !== {4'b0000, 16'd0}) begin bad++; $display("FAIL flush_nocount got=%b exp=%b", {ex_m, bubble_cnt}, {4'b0000, 16'd0}); end
        flush = 1'b0;
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5); tick();
        drive(1'b1, OP, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6);
        stall_in = 1'b1; #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL stall_haz got=%b exp=1", hazard_stall); end
        tick();
        total++; if ({ex_m, bubble_cnt} !== {4'b0001, 16'd0}) begin bad++; $display("FAIL stall_lu_hold got=%b exp=%b", {ex_m, bubble_cnt}, {4'b0001, 16'd0}); end
        stall_in = 1'b0;
        tick();
        total++; if ({ex_m, bubble_cnt} !== {4'b0000, 16'd1}) begin bad++; $display("FAIL stall_lu_release got=%b exp=%b", {ex_m, bubble_cnt}, {4'b0000, 16'd1}); end
        idle();
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 7'h7F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3); tick();
        total++; if ({illegal_ex, ex_ctrl, ex_m} !== {1'b1, 5'b0, 4'b0}) begin
            bad++; $display("FAIL illegal_ex got=%b exp=%b", {illegal_ex, ex_ctrl, ex_m}, {1'b1, 5'b0, 4'b0}); end
        drive(1'b0, 7'h7F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3); tick();
        total++; if ({illegal_ex, mem_m} !== {1'b0, 4'b0}) begin bad++; $display("FAIL invalid_not_illegal got=%b exp=%b", {illegal_ex, mem_m}, {1'b0, 4'b0}); end
        tick();
        total++; if (wb_ctrl !== 3'b000) begin bad++; $display("FAIL illegal_wb got=%b exp=000", wb_ctrl); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat;
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, LOAD, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5); tick();
            drive(1'b1, OP, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6); tick();
            exp_sat = (n > 3) ? 2'd3 : 2'(n);
            total++; if (s_bubble_cnt !== exp_sat) begin bad++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, s_bubble_cnt, exp_sat); end
            total++; if (bubble_cnt !== 16'(n)) begin bad++; $display("FAIL wide_cnt n=%0d got=%0d exp=%0d", n, bubble_cnt, n); end
        end
        drive(1'b1, LOAD, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5); tick();
        drive(1'b1, STORE, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0); tick();
        drive(1'b1, OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(); #1;
        total++; if ({ex_ctrl, ex_m, mem_m, wb_ctrl, wb_rd, illegal_ex, bubble_cnt, s_bubble_cnt} !== 40'd0) begin
            bad++; $display("FAIL midreset got=%b exp=0", {ex_ctrl, ex_m, mem_m, wb_ctrl, wb_rd, illegal_ex, bubble_cnt, s_bubble_cnt}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_back_to_back();
        test_load_use();
        test_no_stall();
        test_flush_stall();
        test_illegal();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
